dcontact_result_writer: RTL and testbench

Collects contact results from the sphere-collision engine and writes each one to result memory as a fixed 10-word record. Sits downstream of the collision core: it detects the core's `done` rising edge, captures contact position, normal, depth, geom IDs and hit flag into a small record FIFO, and drains the FIFO through a word-serial memory write port with an acknowledge handshake. It also pulses the core's reset so the core can accept the next sphere pair.

---
 rtl/dcollide_pkg.sv | 34 +++
 rtl/dcontact_fifo.sv | 50 +++++
 rtl/dcontact_result_writer.sv | 162 ++++++++++++++++
 tb/tb_dcontact_result_writer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcollide_pkg.sv
// Shared types and constants for the contact-result writer: record layout, header fields, writer states.
package dcollide_pkg;

  localparam int RECORD_WORDS  = 10;
  localparam int PAYLOAD_WORDS = 9;
  localparam int HDR_RET_BIT   = 31;
  localparam int HDR_SEQ_LSB   = 0;
  localparam int HDR_SEQ_W     = 16;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wr_state_t;

  // payload[0]=cx ... payload[8]=g2, matching record word offsets 1..9
  typedef struct packed {
    logic                               ret;
    logic [HDR_SEQ_W-1:0]               seq;
    logic [PAYLOAD_WORDS-1:0][31:0]     payload;
  } dcontact_rec_t;

  function automatic logic [31:0] record_word(input dcontact_rec_t rec, input logic [3:0] idx);
    logic [31:0] w;
    w = '0;
    if (idx == 4'd0) begin
      w[HDR_RET_BIT]                 = rec.ret;
      w[HDR_SEQ_LSB +: HDR_SEQ_W]    = rec.seq;
    end else if (idx < 4'(RECORD_WORDS)) begin
      w = rec.payload[idx - 4'd1];
    end
    return w;
  endfunction

endpackage

// File: rtl/dcontact_fifo.sv
// Synchronous FIFO of packed contact records; head is visible combinationally on dout.
module dcontact_fifo
  import dcollide_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      CLK_d,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  dcontact_rec_t             din,
  output dcontact_rec_t             dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);

  dcontact_rec_t   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     cnt;

  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_d) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/dcontact_result_writer.sv
// Captures collider results on done rising edge, queues them, and writes 10-word records to memory.
// Optional build macro DCONTACT_SKIP_MISS_EN drops ret=0 results and counts them in miss_count.
module dcontact_result_writer
  import dcollide_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ADDR_W         = 12,
  parameter int BASE_ADDR      = 0,
  parameter int REGION_RECORDS = 256
) (
  input  logic              CLK_d,
  input  logic              rst,
  input  logic              done,
  input  logic              ret,
  input  logic [31:0]       cx,
  input  logic [31:0]       cy,
  input  logic [31:0]       cz,
  input  logic [31:0]       normalx,
  input  logic [31:0]       normaly,
  input  logic [31:0]       normalz,
  input  logic [31:0]       depth,
  input  logic [31:0]       g1,
  input  logic [31:0]       g2,
  output logic              coll_rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [15:0]       contact_count,
  output logic [15:0]       miss_count,
  output logic              overflow,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            done_q;
  logic [15:0]     seq;
  logic            cap_edge;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   fifo_cnt_nxt;
  dcontact_rec_t   cap_rec;
  dcontact_rec_t   head_rec;
  dcontact_rec_t   rec_q;
  wr_state_t       state;
  logic [3:0]      widx;
  logic [15:0]     rec_idx;
  logic            last_ack;
  logic            wr_next;

  function automatic logic [ADDR_W-1:0] rec_base(input logic [15:0] idx);
    return ADDR_W'(BASE_ADDR + RECORD_WORDS * int'(idx));
  endfunction

  assign cap_edge = done & ~done_q;
`ifdef DCONTACT_SKIP_MISS_EN
  assign push_req = cap_edge & ret;
`else
  assign push_req = cap_edge;
`endif
  // A full FIFO still accepts when the writer pops on the same edge
  assign pop          = (state == ST_IDLE) & ~fifo_empty;
  assign push         = push_req & (~fifo_full | pop);
  assign last_ack     = (state == ST_WRITE) & mem_ack & (widx == 4'(RECORD_WORDS - 1));
  assign wr_next      = pop | ((state == ST_WRITE) & ~last_ack);
  assign fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);

  always_comb begin
    cap_rec         = '0;
    cap_rec.ret     = ret;
    cap_rec.seq     = seq;
    cap_rec.payload = {g2, g1, depth, normalz, normaly, normalx, cz, cy, cx};
  end

  dcontact_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK_d (CLK_d),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cap_rec),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Capture stage: edge detect, sequence numbering, collider rearm
  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      seq        <= '0;
      coll_rst_n <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      done_q     <= done;
      coll_rst_n <= ~cap_edge;
      if (cap_edge)         seq      <= seq + 16'd1;
      if (push_req & ~push) overflow <= 1'b1;
    end
  end

`ifdef DCONTACT_SKIP_MISS_EN
  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst)                miss_count <= '0;
    else if (cap_edge & ~ret) miss_count <= miss_count + 16'd1;
  end
`else
  assign miss_count = '0;
`endif

  always_ff @(posedge CLK_d) begin
    if (pop) rec_q <= head_rec;
  end

  // Writer stage: word-serial record output with ack handshake
  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      widx          <= '0;
      rec_idx       <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= ADDR_W'(BASE_ADDR);
      mem_wdata     <= '0;
      contact_count <= '0;
      busy          <= 1'b0;
    end else begin
      busy <= wr_next | (fifo_cnt_nxt != '0);
      case (state)
        ST_IDLE: begin
          if (pop) begin
            widx      <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= rec_base(rec_idx);
            mem_wdata <= record_word(head_rec, 4'd0);
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            if (widx == 4'(RECORD_WORDS - 1)) begin
              mem_we        <= 1'b0;
              contact_count <= contact_count + 16'd1;
              rec_idx       <= (rec_idx == 16'(REGION_RECORDS - 1)) ? '0 : rec_idx + 16'd1;
              state         <= ST_IDLE;
            end else begin
              widx      <= widx + 4'd1;
              mem_addr  <= mem_addr + 1'b1;
              mem_wdata <= record_word(rec_q, widx + 4'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcontact_result_writer.sv
// Scoreboard bench for dcontact_result_writer: a collider model issues results, a monitor checks every accepted write.
module tb_dcontact_result_writer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int BASE   = 32;
  localparam int REGION = 2;

  logic              CLK_d = 1'b0;
  logic              rst   = 1'b0;
  logic              done  = 1'b0;
  logic              ret   = 1'b0;
  logic [31:0]       cx = '0, cy = '0, cz = '0;
  logic [31:0]       normalx = '0, normaly = '0, normalz = '0;
  logic [31:0]       depth = '0, g1 = '0, g2 = '0;
  logic              coll_rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_ack = 1'b0;
  logic [15:0]       contact_count;
  logic [15:0]       miss_count;
  logic              overflow;
  logic              busy;

  always #5 CLK_d = ~CLK_d;

  dcontact_result_writer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .REGION_RECORDS(REGION)
  ) dut (
    .CLK_d(CLK_d), .rst(rst), .done(done), .ret(ret),
    .cx(cx), .cy(cy), .cz(cz),
    .normalx(normalx), .normaly(normaly), .normalz(normalz),
    .depth(depth), .g1(g1), .g2(g2),
    .coll_rst_n(coll_rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ack(mem_ack),
    .contact_count(contact_count), .miss_count(miss_count),
    .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                last;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  int checks  = 0;
  int errors  = 0;
  int pending = 0;
  int m_seq   = 0;
  int m_rec   = 0;
  int m_count = 0;
  int m_miss  = 0;
  bit m_ovf   = 1'b0;
  int ack_mode   = 0;   // 0 tied high, 1 random, 2 held low, 3 stall on word 4
  int stall_left = 0;

  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;
  bit                stalled = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge CLK_d) begin
    #1;
    case (ack_mode)
      0: mem_ack = 1'b1;
      1: mem_ack = 1'($urandom_range(0, 1));
      2: mem_ack = 1'b0;
      default: begin
        if (mem_we && ((int'(mem_addr) - BASE) % 10 == 4) && stall_left > 0) begin
          mem_ack = 1'b0;
          stall_left--;
        end else begin
          mem_ack = 1'b1;
        end
      end
    endcase
  end

  always @(negedge CLK_d) begin
    if (!rst) begin
      stalled = 1'b0;
    end else if (mem_we) begin
      if (stalled) begin
        check("stall_addr_stable", 32'(mem_addr), 32'(prev_addr));
        check("stall_data_stable", mem_wdata, prev_data);
      end
      if (mem_ack) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected", mem_addr, mem_wdata);
        end else begin
          mon_e = expq.pop_front();
          check("write_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("write_data", mem_wdata, mon_e.data);
          if (mon_e.last) pending--;
        end
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
      end
    end
  end

  task automatic randomize_data();
    ret     = 1'($urandom_range(0, 1));
    cx      = $urandom; cy      = $urandom; cz      = $urandom;
    normalx = $urandom; normaly = $urandom; normalz = $urandom;
    depth   = $urandom; g1      = $urandom; g2      = $urandom;
  endtask

  task automatic push_record();
    logic [31:0] words [10];
    int b;
    words[0] = {ret, 15'b0, 16'(m_seq)};
    words[1] = cx;      words[2] = cy;      words[3] = cz;
    words[4] = normalx; words[5] = normaly; words[6] = normalz;
    words[7] = depth;   words[8] = g1;      words[9] = g2;
    b = BASE + 10 * m_rec;
    for (int i = 0; i < 10; i++)
      expq.push_back('{addr: ADDR_W'(b + i), data: words[i], last: (i == 9)});
    m_rec = (m_rec + 1) % REGION;
    pending++;
    m_count++;
  endtask

  task automatic fire();
    bit acc;
    int n;
    @(posedge CLK_d);
    #1;
    acc = 1'b1;
`ifdef DCONTACT_SKIP_MISS_EN
    if (!ret) begin
      acc = 1'b0;
      m_miss++;
    end
`endif
    // the writer holds one record and the FIFO DEPTH more
    if (acc && pending > DEPTH) begin
      acc   = 1'b0;
      m_ovf = 1'b1;
    end
    if (acc) push_record();
    m_seq++;
    done = 1'b1;
    n = 0;
    while (coll_rst_n !== 1'b0 && n < 10) begin
      @(negedge CLK_d);
      n++;
    end
    check("rearm_low", 32'(coll_rst_n), 32'd0);
    done = 1'b0;
    @(negedge CLK_d);
    check("rearm_one_cycle", 32'(coll_rst_n), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 3000) begin
      @(negedge CLK_d);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: %0d words outstanding, busy %0b, required 0 and 0", name, expq.size(), busy);
    end
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
    check({name, "_contact_count"}, 32'(contact_count), 32'(m_count & 16'hFFFF));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_mem_we"},        32'(mem_we),        32'd0);
    check({name, "_mem_addr"},      32'(mem_addr),      32'(BASE));
    check({name, "_mem_wdata"},     mem_wdata,          32'd0);
    check({name, "_coll_rst_n"},    32'(coll_rst_n),    32'd1);
    check({name, "_contact_count"}, 32'(contact_count), 32'd0);
    check({name, "_miss_count"},    32'(miss_count),    32'd0);
    check({name, "_overflow"},      32'(overflow),      32'd0);
    check({name, "_busy"},          32'(busy),          32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(negedge CLK_d);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge CLK_d);

    // single hit with ack tied high
    ack_mode = 0;
    randomize_data();
    ret = 1'b1; cx = 32'h3F80_0000; g1 = 32'd7; g2 = 32'd9;
    fire();
    check("first_word_we",     32'(mem_we),    32'd1);
    check("first_word_addr",   32'(mem_addr),  32'(BASE));
    check("first_word_header", mem_wdata,      32'h8000_0000);
    wait_drain("single");

    // ack stall on word 4
    ack_mode = 3;
    stall_left = 3;
    randomize_data();
    ret = 1'b1;
    fire();
    wait_drain("stall");
    check("stall_consumed", 32'(stall_left), 32'd0);

    // overflow with ack held low, then release
    ack_mode = 2;
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      ret = 1'b1;
      fire();
    end
    check("ovf_overflow", 32'(overflow), 32'(m_ovf));
    check("ovf_busy",     32'(busy),     32'd1);
    ack_mode = 0;
    wait_drain("ovf");

    // miss result
    randomize_data();
    ret = 1'b0;
    fire();
    wait_drain("miss");
    check("miss_count", 32'(miss_count), 32'(m_miss));

    // random traffic with random ack
    ack_mode = 1;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (pending >= DEPTH && n < 500) begin
        @(negedge CLK_d);
        n++;
      end
      randomize_data();
      fire();
      repeat ($urandom_range(0, 4)) @(negedge CLK_d);
    end
    ack_mode = 0;
    wait_drain("random");
    check("random_miss_count", 32'(miss_count), 32'(m_miss));
    check("random_overflow",   32'(overflow),   32'(m_ovf));

    // reset in the middle of a record
    randomize_data();
    ret = 1'b1;
    fire();
    n = 0;
    while (!(mem_we && ((int'(mem_addr) - BASE) % 10 == 5)) && n < 100) begin
      @(negedge CLK_d);
      n++;
    end
    check("midrst_reached_word5", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_we_immediate", 32'(mem_we), 32'd0);
    expq.delete();
    pending = 0; m_seq = 0; m_rec = 0; m_count = 0; m_miss = 0; m_ovf = 1'b0;
    @(negedge CLK_d);
    check_reset_vals("midrst");
    @(negedge CLK_d);
    rst = 1'b1;
    @(negedge CLK_d);
    randomize_data();
    ret = 1'b1;
    fire();
    wait_drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
